// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte producers.
// Optional macro UART_ARB_PRIO0_EN: requester 0 becomes strict high priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int CLK_FREQ   = 10000000,
  parameter int BAUDRATE   = 115200,
  parameter int GUARD_CLKS = 86
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT + GUARD_CLKS;
  localparam int IDX_W        = $clog2(NUM_REQ);
  localparam int CNT_W        = ($clog2(FRAME_CLKS + 1) > 16) ? $clog2(FRAME_CLKS + 1) : 16;

  typedef enum logic [1:0] {IDLE, START, HOLD} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n, winner, idx;
  logic [IDX_W:0]     sum;
  logic               found;
  logic [NUM_REQ-1:0] cand;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_REQ-1:0] ready_n;
  logic [7:0]         data_n;
  logic               start_n, busy_n;
  logic [2:0]         gid_n;

  // Winner search starts just after the last round-robin grant and wraps mod NUM_REQ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cand   = req_valid;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
`ifdef UART_ARB_PRIO0_EN
    cand[0] = 1'b0;
`endif
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = IDX_W'(sum);
      if (!found && cand[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`ifdef UART_ARB_PRIO0_EN
    if (req_valid[0]) begin
      winner = '0;
      found  = 1'b1;
    end
`endif
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    ready_n = '0;
    data_n  = tx_data;
    start_n = 1'b0;
    busy_n  = busy;
    gid_n   = grant_id;
    case (state)
      IDLE: begin
        if (found) begin
          data_n  = req_data[8*winner +: 8];
          ready_n = NUM_REQ'(1) << winner;
          gid_n   = 3'(winner);
          busy_n  = 1'b1;
          state_n = START;
`ifdef UART_ARB_PRIO0_EN
          // Requester-0 grants leave the round-robin order of the others untouched.
          if (winner != '0) ptr_n = winner;
`else
          ptr_n = winner;
`endif
        end
      end
      START: begin
        start_n = 1'b1;
        cnt_n   = CNT_W'(FRAME_CLKS - 2);
        state_n = HOLD;
      end
      HOLD: begin
        if (cnt == '0) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      cnt       <= '0;
      req_ready <= '0;
      tx_data   <= 8'hFF;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= 3'(NUM_REQ - 1);
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      req_ready <= ready_n;
      tx_data   <= data_n;
      tx_start  <= start_n;
      busy      <= busy_n;
      grant_id  <= gid_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at default parameters (frame = 946 cycles).
// The priority test is compiled only when UART_ARB_PRIO0_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int FRAME = 946;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         busy;
  logic [2:0]   grant_id;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  uart_tx_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Bounded wait for the next acknowledge; rdy stays 0 on timeout.
  task automatic wait_grant(input int budget, output logic [N-1:0] rdy);
    rdy = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        rdy = req_ready;
        return;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (grant_id !== 3'd3) begin n_err++; $display("FAIL reset_grant_id: got %0d want 3", grant_id); end
    n_cmp++; if (tx_data !== 8'hFF) begin n_err++; $display("FAIL reset_tx_data: got %h want ff", tx_data); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int busy_cnt;
    bit stable;
    bit ok;
    @(negedge clk);
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    n_cmp++; if (grant_id !== 3'd2) begin n_err++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
    n_cmp++; if (busy !== 1'b1 || tx_start !== 1'b0) begin n_err++; $display("FAIL single_grant_cycle: busy %b start %b want 1 0", busy, tx_start); end
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (tx_start !== 1'b1 || req_ready !== 4'b0000) begin n_err++; $display("FAIL single_start: start %b ready %b want 1 0000", tx_start, req_ready); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
    busy_cnt = 2;
    stable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
      if (tx_data !== 8'hA5 || tx_start !== 1'b0 || req_ready !== 4'b0000) stable = 1'b0;
    end
    n_cmp++; if (busy_cnt !== FRAME) begin n_err++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, FRAME); end
    n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL single_hold_stable: outputs changed during hold"); end
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_idle: busy stuck high"); end
  endtask

  task automatic test_all_valid();
    logic [N-1:0] rdy;
    logic [7:0] exp_byte [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    int t_start [4];
    bit ok;
    do_reset();
    req_data = 32'h4332_2110;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(1200, rdy);
      n_cmp++; if (rdy !== (4'b0001 << k)) begin n_err++; $display("FAIL all_ready[%0d]: got %b want %b", k, rdy, 4'b0001 << k); end
      n_cmp++; if (grant_id !== 3'(k)) begin n_err++; $display("FAIL all_grant_id[%0d]: got %0d want %0d", k, grant_id, k); end
      req_valid[k] = 1'b0;
      @(negedge clk);
      t_start[k] = cyc;
      n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL all_start[%0d]: got %b want 1", k, tx_start); end
      n_cmp++; if (tx_data !== exp_byte[k]) begin n_err++; $display("FAIL all_tx_data[%0d]: got %h want %h", k, tx_data, exp_byte[k]); end
      if (k > 0) begin
        n_cmp++; if (t_start[k] - t_start[k-1] !== FRAME + 1) begin n_err++; $display("FAIL all_spacing[%0d]: got %0d want %0d", k, t_start[k] - t_start[k-1], FRAME + 1); end
      end
    end
    req_valid = '0;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL all_idle: busy stuck high"); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] rdy;
    logic [N-1:0] exp;
    bit ok;
    req_data = 32'hB300_B100;
    req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      exp = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      wait_grant(1200, rdy);
      n_cmp++; if (rdy !== exp) begin n_err++; $display("FAIL fair_ready[%0d]: got %b want %b", k, rdy, exp); end
      n_cmp++; if (grant_id !== ((k % 2 == 0) ? 3'd1 : 3'd3)) begin n_err++; $display("FAIL fair_grant_id[%0d]: got %0d want %0d", k, grant_id, (k % 2 == 0) ? 1 : 3); end
    end
    req_valid = '0;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL fair_idle: busy stuck high"); end
  endtask

  task automatic test_ignored_busy();
    logic [N-1:0] rdy;
    int busy_cnt;
    bit bad;
    bit late;
    req_data[15:8] = 8'h5A;
    req_valid = 4'b0010;
    wait_grant(1200, rdy);
    n_cmp++; if (rdy !== 4'b0010) begin n_err++; $display("FAIL ign_ready: got %b want 0010", rdy); end
    req_valid = '0;
    busy_cnt = 1;
    bad = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 300) begin
        req_data[7:0] = 8'hEE;
        req_valid = 4'b0001;
      end
      if (i == 305) req_valid = '0;
      if (!busy) break;
      busy_cnt++;
      if (req_ready !== 4'b0000 || tx_data !== 8'h5A) bad = 1'b1;
    end
    n_cmp++; if (busy_cnt !== FRAME) begin n_err++; $display("FAIL ign_busy_len: got %0d want %0d", busy_cnt, FRAME); end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL ign_during_busy: ready or tx_data changed"); end
    late = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (req_ready !== 4'b0000 || tx_data !== 8'h5A) late = 1'b1;
    end
    n_cmp++; if (late !== 1'b0) begin n_err++; $display("FAIL ign_not_queued: dropped request was granted"); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] rdy;
    bit ok;
    req_data[23:16] = 8'h77;
    req_valid = 4'b0100;
    wait_grant(1200, rdy);
    n_cmp++; if (rdy !== 4'b0100) begin n_err++; $display("FAIL rst_mid_ready: got %b want 0100", rdy); end
    req_valid = '0;
    repeat (301) @(negedge clk);
    req_data[7:0] = 8'h99;
    req_valid = 4'b0001;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_data !== 8'hFF) begin n_err++; $display("FAIL rst_mid_tx_data: got %h want ff", tx_data); end
    n_cmp++; if (busy !== 1'b0 || tx_start !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_mid_ctrl: busy %b start %b ready %b want 0 0 0000", busy, tx_start, req_ready); end
    n_cmp++; if (grant_id !== 3'd3) begin n_err++; $display("FAIL rst_mid_grant_id: got %0d want 3", grant_id); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001 || grant_id !== 3'd0) begin n_err++; $display("FAIL rst_mid_regrant: ready %b id %0d want 0001 0", req_ready, grant_id); end
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h99) begin n_err++; $display("FAIL rst_mid_start: start %b data %h want 1 99", tx_start, tx_data); end
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rst_mid_idle: busy stuck high"); end
  endtask

`ifdef UART_ARB_PRIO0_EN
  task automatic test_prio0();
    logic [N-1:0] rdy;
    do_reset();
    req_data = 32'h00C2_00C0;
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      wait_grant(1200, rdy);
      n_cmp++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL prio_ready[%0d]: got %b want 0001", k, rdy); end
    end
    req_valid[0] = 1'b0;
    wait_grant(1200, rdy);
    n_cmp++; if (rdy !== 4'b0100 || grant_id !== 3'd2) begin n_err++; $display("FAIL prio_fallback: ready %b id %0d want 0100 2", rdy, grant_id); end
    req_valid = '0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_fairness();
    test_ignored_busy();
    test_reset_mid();
`ifdef UART_ARB_PRIO0_EN
    test_prio0();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer among NUM_REQ byte producers using round-robin arbitration.
- Accepts one byte per grant through a per-requester valid/ready handshake.
- Pulses the serializer's start input for one cycle and holds its data byte stable for a full frame.
- The serializer has no busy output and samples its data input bit by bit, so this block times the frame itself.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
CLK_FREQ, 10000000, system clock frequency in Hz.
BAUDRATE, 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ / BAUDRATE (integer division, 86 at defaults).
GUARD_CLKS, 86, extra idle cycles after each frame before the next start pulse.
FRAME_CLKS (derived), 10*CLKS_PER_BIT + GUARD_CLKS (946 at defaults), total cycles per granted byte.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
req_valid  input  NUM_REQ  bit i high: requester i offers a byte.
req_data  input  8*NUM_REQ  requester i byte on bits [8*i+7:8*i].
req_ready  output  NUM_REQ  one-hot, one-cycle acknowledge: byte of requester i accepted.
tx_data  output  8  byte to the serializer's data_byte input.
tx_start  output  1  one-cycle pulse to the serializer's data_ready input.
busy  output  1  high from the grant cycle through the last guard cycle.
grant_id  output  3  index of the most recently granted requester.

Behaviour:
- Reset values (rst high at a clock edge):
  - req_ready=0, tx_start=0, busy=0, grant_id=NUM_REQ-1.
  - tx_data=8'hFF, so any frame still in flight in the serializer finishes at mark level.
  - Round-robin pointer = NUM_REQ-1; state=IDLE; frame counter=0.
- States:
  - IDLE: busy=0. If any req_valid is high, choose winner w = first valid index searching pointer+1, pointer+2, ... mod NUM_REQ.
    - Same cycle (registered): tx_data<=req_data[w]; req_ready[w]<=1; grant_id<=w; pointer<=w; busy<=1.
    - Next state START.
  - START: one cycle; tx_start=1, req_ready=0.
    - Counter loads FRAME_CLKS-2 (FRAME_CLKS counts from the grant cycle).
    - Next state HOLD.
  - HOLD: tx_start=0; counter decrements each cycle.
    - At 0: busy<=0, next state IDLE.
    - A request pending at that point is granted on the first IDLE cycle.
- Latency and spacing:
  - Grant edge to tx_start high is exactly 1 cycle.
  - Consecutive tx_start pulses are exactly FRAME_CLKS+1 cycles apart under continuous demand.
- tx_data changes only on a grant edge or reset. It is stable from START through the end of HOLD.
- Handshake rules:
  - Requester holds valid and data until it sees req_ready; the byte is consumed on that cycle.
  - Valid may be dropped before ready with no effect.
  - req_valid during busy is ignored; it is not queued.
- Round-robin fairness:
  - A requester just granted has lowest priority at the next decision.
  - With k requesters continuously valid, each is granted once per k frames.
- Width rules:
  - Counter width covers FRAME_CLKS (at least 16 bits).
  - Pointer arithmetic wraps mod NUM_REQ, not mod 8.
- Reset mid-operation: all outputs return to reset values on the next edge. A byte being acknowledged in that cycle is dropped (req_ready forced 0).
- Simultaneous valids: exactly one req_ready bit is ever high.

Optional Feature:
UART_ARB_PRIO0_EN
- Defined: requester 0 is strict high priority. Whenever req_valid[0] is high in IDLE it wins. Other requesters round-robin among themselves, and their pointer is not updated by requester-0 grants.
- Undefined: pure round-robin over all NUM_REQ requesters, as in Behaviour.

Test Plan:
- Single request: after reset, req_valid=4'b0100, byte 8'hA5 → req_ready=4'b0100 for 1 cycle, grant_id=2, tx_start 1 cycle later, tx_data=8'hA5 held; busy high 946 cycles.
- All valid at once after reset, bytes 0x10/0x21/0x32/0x43 → grants in order 0,1,2,3; tx_start pulses 947 cycles apart; tx_data sequence 10,21,32,43.
- Fairness: requesters 1 and 3 continuously valid → grant_id alternates 1,3,1,3 over 6 frames; no other req_ready bit ever set.
- Ignored during busy: requester 0 pulses valid for 5 cycles mid-HOLD then drops → no grant, tx_data unchanged, busy timing unaffected.
- Reset mid-frame: assert rst at cycle 300 of HOLD → next edge tx_data=8'hFF, busy=0, tx_start=0, grant_id=NUM_REQ-1. Pending valid on 0 is granted on the first cycle after rst drops.
- With UART_ARB_PRIO0_EN: requesters 0 and 2 continuously valid → requester 0 granted every frame, requester 2 never. Drop requester 0 → requester 2 granted on the next IDLE.
